// File: rtl/cv32e40px_obi_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : cv32e40px_obi_pkg                                                  |
// | Brief  : Shared OBI data-port widths and the request pass-through bundle.   |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

package cv32e40px_obi_pkg;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_BE_W   = 4;

    typedef struct packed {
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_ADDR_W-1:0] addr;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_req_t;

endpackage

`default_nettype wire

// File: rtl/cv32e40px_obi_outstanding_cnt.sv
// +----------------------------------------------------------------------------+
// | Module : cv32e40px_obi_outstanding_cnt                                      |
// | Brief  : Saturating up/down counter of granted-but-unanswered transactions. |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module cv32e40px_obi_outstanding_cnt
    import cv32e40px_obi_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 2,
    parameter int unsigned CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_max_o,
    output logic             is_zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign at_max_o  = (count_q == CNT_W'(MAX_COUNT));
    assign is_zero_o = (count_q == '0);
    assign count_o   = count_q;

    // Simultaneous inc and dec cancel; both ends saturate rather than wrap.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !at_max_o) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i && !is_zero_o) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cv32e40px_obi_throttle.sv
// +----------------------------------------------------------------------------+
// | Module : cv32e40px_obi_throttle                                             |
// | Brief  : OBI data-port outstanding limiter with drain handshake and         |
// |          sticky orphan-response error.                                      |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module cv32e40px_obi_throttle
    import cv32e40px_obi_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned RSP_REG         = 0,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  core_req_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    input  logic                  core_we_i,
    input  logic [OBI_BE_W-1:0]   core_be_i,
    input  logic [OBI_ADDR_W-1:0] core_addr_i,
    input  logic [OBI_DATA_W-1:0] core_wdata_i,
    output logic [OBI_DATA_W-1:0] core_rdata_o,
    output logic                  bus_req_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    output logic                  bus_we_o,
    output logic [OBI_BE_W-1:0]   bus_be_o,
    output logic [OBI_ADDR_W-1:0] bus_addr_o,
    output logic [OBI_DATA_W-1:0] bus_wdata_o,
    input  logic [OBI_DATA_W-1:0] bus_rdata_i,
    input  logic                  drain_req_i,
    output logic                  drained_o,
    output logic [CNT_W-1:0]      outstanding_o,
    output logic                  err_o
);

    obi_req_t w_core_req;
    logic     w_block;
    logic     w_inc;
    logic     w_dec;
    logic     w_at_max;
    logic     w_is_zero;
    logic     w_rsp_valid;
    logic     w_drain_idle;

    logic     pending_q;
    logic     pending_d;
    logic     err_q;
    logic     err_d;

    assign w_core_req = '{we: core_we_i, be: core_be_i, addr: core_addr_i, wdata: core_wdata_i};
    assign bus_we_o    = w_core_req.we;
    assign bus_be_o    = w_core_req.be;
    assign bus_addr_o  = w_core_req.addr;
    assign bus_wdata_o = w_core_req.wdata;

    // A presented request may not be retracted, so pending overrides drain/limit.
    assign w_block    = ~pending_q & (drain_req_i | w_at_max);
    assign bus_req_o  = core_req_i & ~w_block & ~rst_i;
    assign core_gnt_o = bus_req_o & bus_gnt_i;

    assign w_inc       = bus_req_o & bus_gnt_i;
    assign w_dec       = bus_rvalid_i & ~w_is_zero;
    assign w_rsp_valid = w_dec;

    always_comb begin
        pending_d = bus_req_o & ~bus_gnt_i;
        err_d     = err_q | (bus_rvalid_i & w_is_zero);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    cv32e40px_obi_outstanding_cnt #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (w_inc),
        .dec_i     (w_dec),
        .count_o   (outstanding_o),
        .at_max_o  (w_at_max),
        .is_zero_o (w_is_zero)
    );

    assign err_o        = err_q;
    assign w_drain_idle = drain_req_i & ~pending_q & w_is_zero;

    if (RSP_REG != 0) begin : g_rsp_reg
        logic                  rvalid_q;
        logic                  rvalid_d;
        logic [OBI_DATA_W-1:0] rdata_q;
        logic [OBI_DATA_W-1:0] rdata_d;

        always_comb begin
            rvalid_d = w_rsp_valid;
            rdata_d  = w_rsp_valid ? bus_rdata_i : rdata_q;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rvalid_d;
                rdata_q  <= rdata_d;
            end
        end

        assign core_rvalid_o = rvalid_q;
        assign core_rdata_o  = rdata_q;
        // A response still in flight to the core keeps the port busy.
        assign drained_o     = w_drain_idle & ~rvalid_q;
    end else begin : g_rsp_comb
        assign core_rvalid_o = w_rsp_valid;
        assign core_rdata_o  = bus_rdata_i;
        assign drained_o     = w_drain_idle;
    end

endmodule

`default_nettype wire

// File: tb/tb_cv32e40px_obi_throttle.sv
// +----------------------------------------------------------------------------+
// | Module : tb_cv32e40px_obi_throttle                                          |
// | Brief  : Directed bench driving RSP_REG=0 and RSP_REG=1 instances in step.  |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cv32e40px_obi_throttle;

    localparam logic [31:0] J = 32'hBAD0BAD0;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, bus_gnt, bus_rvalid, drain;
    logic        core_we;
    logic [3:0]  core_be;
    logic [31:0] core_addr, core_wdata, bus_rdata;

    logic        gnt0, rv0, breq0, bwe0, drn0, err0;
    logic [3:0]  bbe0;
    logic [31:0] rd0, baddr0, bwd0;
    logic [1:0]  out0;
    logic        gnt1, rv1, breq1, bwe1, drn1, err1;
    logic [3:0]  bbe1;
    logic [31:0] rd1, baddr1, bwd1;
    logic [1:0]  out1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cv32e40px_obi_throttle #(.MAX_OUTSTANDING(2), .RSP_REG(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .core_req_i(core_req), .core_gnt_o(gnt0),
        .core_rvalid_o(rv0), .core_we_i(core_we), .core_be_i(core_be),
        .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_rdata_o(rd0),
        .bus_req_o(breq0), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid),
        .bus_we_o(bwe0), .bus_be_o(bbe0), .bus_addr_o(baddr0), .bus_wdata_o(bwd0),
        .bus_rdata_i(bus_rdata), .drain_req_i(drain), .drained_o(drn0),
        .outstanding_o(out0), .err_o(err0)
    );

    cv32e40px_obi_throttle #(.MAX_OUTSTANDING(2), .RSP_REG(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .core_req_i(core_req), .core_gnt_o(gnt1),
        .core_rvalid_o(rv1), .core_we_i(core_we), .core_be_i(core_be),
        .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_rdata_o(rd1),
        .bus_req_o(breq1), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid),
        .bus_we_o(bwe1), .bus_be_o(bbe1), .bus_addr_o(baddr1), .bus_wdata_o(bwd1),
        .bus_rdata_i(bus_rdata), .drain_req_i(drain), .drained_o(drn1),
        .outstanding_o(out1), .err_o(err1)
    );

    typedef struct {
        logic        req, gnt, rv;
        logic [31:0] rdata;
        logic        drain;
        logic        e_breq, e_cgnt, e_rv0, e_rv1;
        logic [31:0] e_rd1;
        logic [1:0]  e_out;
        logic        e_err, e_drn0, e_drn1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic req, gnt, rv, input logic [31:0] rdata, input logic drn,
        input logic e_breq, e_cgnt, e_rv0, e_rv1, input logic [31:0] e_rd1,
        input logic [1:0] e_out, input logic e_err, e_drn0, e_drn1);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.drain = drn;
        v.e_breq = e_breq; v.e_cgnt = e_cgnt; v.e_rv0 = e_rv0; v.e_rv1 = e_rv1;
        v.e_rd1 = e_rd1; v.e_out = e_out; v.e_err = e_err;
        v.e_drn0 = e_drn0; v.e_drn1 = e_drn1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic req, gnt, rv, input logic [31:0] rd, input logic drn);
        core_req = req; bus_gnt = gnt; bus_rvalid = rv; bus_rdata = rd; drain = drn;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        core_we = 1'b1; core_be = 4'h5; core_addr = 32'h8000_1234; core_wdata = 32'h0BAD_F00D;
        drive(1'b1, 1'b1, 1'b0, J, 1'b0);

        // Back-to-back reads hitting the limit, then a drain sequence.
        vecs.push_back(mk(1,1,0,J,0,           1,1,0,0,32'h0,0,0,0,0));
        vecs.push_back(mk(1,1,0,J,0,           1,1,0,0,32'h0,1,0,0,0));
        vecs.push_back(mk(1,1,0,J,0,           0,0,0,0,32'h0,2,0,0,0));
        vecs.push_back(mk(1,1,1,32'hDEADBEEF,0, 0,0,1,0,32'h0,2,0,0,0));
        vecs.push_back(mk(1,1,1,32'h11111111,0, 1,1,1,1,32'hDEADBEEF,1,0,0,0));
        vecs.push_back(mk(0,0,0,J,0,           0,0,0,1,32'h11111111,1,0,0,0));
        vecs.push_back(mk(0,0,0,J,0,           0,0,0,0,32'h11111111,1,0,0,0));
        vecs.push_back(mk(0,0,1,32'hCAFEF00D,0, 0,0,1,0,32'h11111111,1,0,0,0));
        vecs.push_back(mk(0,0,0,J,0,           0,0,0,1,32'hCAFEF00D,0,0,0,0));
        vecs.push_back(mk(1,0,0,J,0,           1,0,0,0,32'hCAFEF00D,0,0,0,0));
        vecs.push_back(mk(1,0,0,J,1,           1,0,0,0,32'hCAFEF00D,0,0,0,0));
        vecs.push_back(mk(1,0,0,J,1,           1,0,0,0,32'hCAFEF00D,0,0,0,0));
        vecs.push_back(mk(1,1,0,J,1,           1,1,0,0,32'hCAFEF00D,0,0,0,0));
        vecs.push_back(mk(1,1,0,J,1,           0,0,0,0,32'hCAFEF00D,1,0,0,0));
        vecs.push_back(mk(1,1,1,32'hA5A5A5A5,1, 0,0,1,0,32'hCAFEF00D,1,0,0,0));
        vecs.push_back(mk(1,1,0,J,1,           0,0,0,1,32'hA5A5A5A5,0,0,1,0));
        vecs.push_back(mk(1,1,0,J,1,           0,0,0,0,32'hA5A5A5A5,0,0,1,1));
        vecs.push_back(mk(1,1,0,J,0,           1,1,0,0,32'hA5A5A5A5,0,0,0,0));
        vecs.push_back(mk(0,0,1,32'h5A5A5A5A,0, 0,0,1,0,32'hA5A5A5A5,1,0,0,0));
        vecs.push_back(mk(0,0,0,J,0,           0,0,0,1,32'h5A5A5A5A,0,0,0,0));

        step(); step();
        #3;
        chk("rst_bus_req0", breq0, 0);
        chk("rst_bus_req1", breq1, 0);
        chk("rst_core_gnt0", gnt0, 0);
        chk("pass_we", bwe0, 1);
        chk("pass_be", bbe1, 4'h5);
        chk("pass_addr", baddr0, 32'h8000_1234);
        chk("pass_wdata", bwd1, 32'h0BAD_F00D);

        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, J, 1'b0);
        #3;
        chk("reset_out0", out0, 0);
        chk("reset_err1", err1, 0);
        chk("reset_rv1", rv1, 0);
        chk("reset_rd1", rd1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step();
            drive(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].drain);
            #3;
            chk($sformatf("v%0d_bus_req0", i), breq0, vecs[i].e_breq);
            chk($sformatf("v%0d_bus_req1", i), breq1, vecs[i].e_breq);
            chk($sformatf("v%0d_core_gnt", i), gnt0, vecs[i].e_cgnt);
            chk($sformatf("v%0d_rvalid0", i), rv0, vecs[i].e_rv0);
            if (vecs[i].e_rv0)
                chk($sformatf("v%0d_rdata0", i), rd0, vecs[i].rdata);
            chk($sformatf("v%0d_rvalid1", i), rv1, vecs[i].e_rv1);
            chk($sformatf("v%0d_rdata1", i), rd1, vecs[i].e_rd1);
            chk($sformatf("v%0d_outst0", i), out0, vecs[i].e_out);
            chk($sformatf("v%0d_outst1", i), out1, vecs[i].e_out);
            chk($sformatf("v%0d_err", i), err0, vecs[i].e_err);
            chk($sformatf("v%0d_drained0", i), drn0, vecs[i].e_drn0);
            chk($sformatf("v%0d_drained1", i), drn1, vecs[i].e_drn1);
        end

        // Registered response: single read answered four cycles after grant.
        step(); drive(1'b1, 1'b1, 1'b0, J, 1'b0); #3;
        chk("sr_gnt", gnt1, 1);
        for (int c = 1; c < 4; c++) begin
            step(); drive(1'b0, 1'b0, 1'b0, J, 1'b0); #3;
            chk($sformatf("sr_idle%0d_rv1", c), rv1, 0);
        end
        step(); drive(1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0); #3;
        chk("sr_c4_rv1", rv1, 0);
        chk("sr_c4_rv0", rv0, 1);
        chk("sr_c4_out", out1, 1);
        step(); drive(1'b0, 1'b0, 1'b0, J, 1'b0); #3;
        chk("sr_c5_rv1", rv1, 1);
        chk("sr_c5_rd1", rd1, 32'h12345678);
        step(); #3;
        chk("sr_c6_rv1", rv1, 0);
        chk("sr_c6_rd1_hold", rd1, 32'h12345678);

        // Orphan response sets the sticky error, which only reset clears.
        step(); drive(1'b0, 1'b0, 1'b1, 32'h77777777, 1'b0); #3;
        chk("orph_rv0", rv0, 0);
        chk("orph_err_same_cycle", err0, 0);
        step(); drive(1'b0, 1'b0, 1'b0, J, 1'b0); #3;
        chk("orph_err0", err0, 1);
        chk("orph_err1", err1, 1);
        chk("orph_rv1", rv1, 0);
        chk("orph_out", out0, 0);
        step(); drive(1'b1, 1'b1, 1'b0, J, 1'b0); #3;
        chk("orph_traffic_gnt", gnt0, 1);
        step(); drive(1'b0, 1'b0, 1'b1, 32'h88888888, 1'b0); #3;
        chk("orph_traffic_rv0", rv0, 1);
        chk("orph_err_persist", err0, 1);
        step(); drive(1'b1, 1'b1, 1'b0, J, 1'b0); #3;
        step(); drive(1'b1, 1'b1, 1'b0, J, 1'b0); #3;
        chk("prerst_out", out0, 1);
        step(); drive(1'b1, 1'b0, 1'b1, 32'h99999999, 1'b0); #3;
        chk("prerst_out2", out1, 2);
        chk("prerst_err", err1, 1);
        rst = 1'b1;
        #1;
        chk("inrst_bus_req", breq0, 0);
        chk("inrst_gnt", gnt1, 0);
        step(); rst = 1'b0; drive(1'b0, 1'b0, 1'b0, J, 1'b0); #3;
        chk("postrst_out0", out0, 0);
        chk("postrst_out1", out1, 0);
        chk("postrst_bus_req", breq0, 0);
        chk("postrst_err0", err0, 0);
        chk("postrst_err1", err1, 0);
        chk("postrst_rv0", rv0, 0);
        chk("postrst_rv1", rv1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cv32e40px_obi_throttle.md
Name: cv32e40px_obi_throttle

Overview:
- Sits directly downstream of the core's data memory port (data_req/gnt/rvalid OBI-style interface), between the core top and the system bus.
- Limits the number of outstanding transactions to a parameterised maximum.
- Provides a drain handshake so SoC logic can safely gate the core/bus clock.
- Optionally registers the response path and flags protocol violations (orphan rvalid) with a sticky error.

Parameters:
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (1..15).
- RSP_REG, 0, 1 = register rvalid/rdata towards the core (+1 cycle latency); 0 = combinational pass-through.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived; not to be overridden).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- core_req_i  in  1  core request.
- core_gnt_o  out  1  grant to core.
- core_rvalid_o  out  1  response valid to core.
- core_we_i  in  1  write enable.
- core_be_i  in  4  byte enables.
- core_addr_i  in  32  address.
- core_wdata_i  in  32  write data.
- core_rdata_o  out  32  read data to core.
- bus_req_o  out  1  request to bus.
- bus_gnt_i  in  1  bus grant.
- bus_rvalid_i  in  1  bus response valid.
- bus_we_o  out  1  write enable (pass-through).
- bus_be_o  out  4  byte enables (pass-through).
- bus_addr_o  out  32  address (pass-through).
- bus_wdata_o  out  32  write data (pass-through).
- bus_rdata_i  in  32  bus read data.
- drain_req_i  in  1  request to stop issuing and empty.
- drained_o  out  1  no pending or outstanding transactions while drain requested.
- outstanding_o  out  CNT_W  current outstanding count.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_i=1 at clock edge) clears:
  - cnt_q=0, pending_q=0, err_q=0.
  - Response regs: rvalid_q=0, rdata_q=0.
- While rst_i=1, bus_req_o and core_gnt_o are forced to 0.
- Reset mid-transaction discards all state. Bus-side cleanup is the system's responsibility.
- pending_q:
  - Set when bus_req_o=1 and bus_gnt_i=0.
  - Cleared on grant.
  - OBI forbids retracting a presented request.
- block = ~pending_q & (drain_req_i | cnt_q==MAX_OUTSTANDING).
- bus_req_o = core_req_i & ~block & ~rst_i.
- A request already presented (pending_q=1) stays forwarded regardless of drain or limit.
- No same-cycle bypass at the limit: cnt_q==MAX with simultaneous bus_rvalid_i still blocks that cycle.
- core_gnt_o = bus_req_o & bus_gnt_i. Zero added request latency.
- bus_we/be/addr/wdata are combinational pass-throughs of the core_* inputs.
- Counter:
  - inc = bus_req_o & bus_gnt_i.
  - dec = bus_rvalid_i & (cnt_q!=0).
  - cnt_d = cnt_q + inc - dec.
  - Simultaneous inc and dec leaves the count unchanged.
  - The count never wraps. By construction inc is impossible at MAX (given no pending at MAX).
- outstanding_o = cnt_q.
- Orphan rvalid (bus_rvalid_i=1 with cnt_q==0):
  - err_q is set and stays set until reset.
  - The response is dropped; it is not forwarded to the core.
- Response path:
  - RSP_REG=0: core_rvalid_o = bus_rvalid_i & (cnt_q!=0); core_rdata_o = bus_rdata_i.
  - RSP_REG=1: rvalid_q <= that same term.
  - RSP_REG=1: rdata_q loads bus_rdata_i only when the term is 1, and holds otherwise.
  - RSP_REG=1: outputs come from the registers, giving 1 cycle latency. No backpressure exists, so no FIFO.
- drained_o = drain_req_i & ~pending_q & (cnt_q==0).
  - With RSP_REG=1 it also requires rvalid_q==0.
- Drain deassertion resumes issuing in the same cycle.

Decomposition:
- Shared package cv32e40px_obi_pkg holds:
  - OBI_ADDR_W=32, OBI_DATA_W=32, OBI_BE_W=4.
  - A typedef obi_req_t {we, be, addr, wdata} for the pass-through bundle.
- One natural sub-module, cv32e40px_obi_outstanding_cnt:
  - Ports: inc, dec, count, at_max, is_zero.
  - Contains the saturating up/down counter, reused later on the instruction port.

Test Plan:
- MAX=2, RSP_REG=0, three back-to-back reads with gnt=1, rvalid delayed 3 cycles -> reqs 1-2 granted in cycles 0-1; req 3 blocked (bus_req_o=0, outstanding_o=2) until the first rvalid; granted in the cycle after; rdata 0xDEADBEEF appears on core_rdata_o in the same cycle as bus_rvalid_i.
- RSP_REG=1, single read, rvalid at cycle 4 with 0x12345678 -> core_rvalid_o=1 and core_rdata_o=0x12345678 at cycle 5 only; rdata holds afterwards.
- Request presented with gnt=0 for 3 cycles, drain_req_i raised in cycle 1 -> bus_req_o stays 1 until gnt; drained_o=1 only after that transaction's rvalid; a subsequent core_req_i is blocked.
- Simultaneous gnt and rvalid at cnt=1 -> outstanding_o stays 1; err_o stays 0.
- bus_rvalid_i pulse with cnt=0 -> core_rvalid_o=0; err_o=1 from the next cycle and persists through later traffic; cleared only by a rst_i pulse.
- rst_i asserted with cnt=2 and a request pending -> the next cycle shows outstanding_o=0, bus_req_o=0, err_o=0, core_rvalid_o=0.
